// File: rtl/uart_pkg.sv
// Shared UART types for the receive-path parity checker.
//   par_mode_e      : parity modes as encoded on PAR_MODE
//   par_chk_state_e : parity checker FSM states
//   par_expected()  : expected parity bit for a mode and accumulated XOR
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_MARK  = 2'd2,
    PAR_SPACE = 2'd3
  } par_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    WAIT_PAR = 2'd2
  } par_chk_state_e;

  // acc is the XOR of all data bits received so far in the frame.
  function automatic logic par_expected(input par_mode_e mode, input logic acc);
    logic exp_bit;
    exp_bit = 1'b0;
    case (mode)
      PAR_EVEN:  exp_bit = acc;
      PAR_ODD:   exp_bit = ~acc;
      PAR_MARK:  exp_bit = 1'b1;
      PAR_SPACE: exp_bit = 1'b0;
      default:   exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// Generic saturating up-counter with synchronous clear.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous clear; wins over inc in the same cycle
//   inc  : add one, unless already at all-ones
//   cnt  : current count
module uart_sat_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_par_chk_seq.sv
// Sequential UART receive parity checker.
// Accumulates parity one data bit at a time, compares the sampled parity bit
// against the expected value for the mode latched at frame_start, and flags
// strobe-ordering violations.
//
// Optional build macro: UART_PAR_ERR_CNT_EN adds a saturating parity-error
// counter on err_cnt (cleared by err_cnt_clr). Without it err_cnt is tied 0.
//
// Ports:
//   CLK          : clock, rising edge
//   RST          : synchronous active-high reset
//   PAR_EN       : parity enable, sampled on frame_start
//   PAR_MODE     : 0 even, 1 odd, 2 mark, 3 space; sampled on frame_start
//   frame_start  : start-bit accept pulse; aborts any frame and re-arms
//   data_bit_vld : data_bit is a sampled data bit
//   data_bit     : data bit value
//   par_bit_vld  : par_bit is the sampled parity bit
//   par_bit      : parity bit value
//   par_done     : one-cycle pulse, par_err valid
//   par_err      : parity mismatch, held until next frame_start or RST
//   seq_err      : one-cycle pulse on a strobe ordering violation
//   err_cnt      : saturating parity-error count
//   err_cnt_clr  : synchronous clear of err_cnt
module uart_par_chk_seq
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic                 frame_start,
  input  logic                 data_bit_vld,
  input  logic                 data_bit,
  input  logic                 par_bit_vld,
  input  logic                 par_bit,
  output logic                 par_done,
  output logic                 par_err,
  output logic                 seq_err,
  output logic [CNT_WIDTH-1:0] err_cnt,
  input  logic                 err_cnt_clr
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastCnt = BitCntW'(DATA_WIDTH);

  if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9)) begin : gen_bad_width
    $error("uart_par_chk_seq: DATA_WIDTH must be 5..9");
  end

  par_chk_state_e       state_q, state_d;
  par_mode_e            mode_q, mode_d;
  logic                 acc_q, acc_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 par_done_q, par_done_d;
  logic                 par_err_q, par_err_d;
  logic                 seq_err_q, seq_err_d;

  // PAR_EN needs no register of its own: a disabled frame never leaves IDLE,
  // so being in ACCUM/WAIT_PAR already implies the frame was enabled.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    par_err_d  = par_err_q;
    par_done_d = 1'b0;
    seq_err_d  = 1'b0;

    if (frame_start) begin
      // Re-arm from any state; strobes in this cycle are ignored.
      mode_d    = par_mode_e'(PAR_MODE);
      acc_d     = 1'b0;
      bit_cnt_d = '0;
      par_err_d = 1'b0;
      state_d   = PAR_EN ? ACCUM : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Stray strobes outside a frame are not an error.
        end

        ACCUM: begin
          if (par_bit_vld) begin
            // Early parity, alone or together with a data strobe.
            seq_err_d = 1'b1;
            par_err_d = 1'b0;
            state_d   = IDLE;
          end else if (data_bit_vld) begin
            acc_d     = acc_q ^ data_bit;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            if (bit_cnt_d == LastCnt) begin
              state_d = WAIT_PAR;
            end
          end
        end

        WAIT_PAR: begin
          if (data_bit_vld) begin
            // Extra data bit, alone or together with the parity strobe.
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end else if (par_bit_vld) begin
            par_err_d  = (par_expected(mode_q, acc_q) != par_bit);
            par_done_d = 1'b1;
            state_d    = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      mode_q     <= PAR_EVEN;
      acc_q      <= 1'b0;
      bit_cnt_q  <= '0;
      par_done_q <= 1'b0;
      par_err_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      par_done_q <= par_done_d;
      par_err_q  <= par_err_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign par_done = par_done_q;
  assign par_err  = par_err_q;
  assign seq_err  = seq_err_q;

`ifdef UART_PAR_ERR_CNT_EN
  logic err_inc;

  // Counts on the cycle the failed check is presented.
  assign err_inc = par_done_q & par_err_q;

  uart_sat_cnt #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk(CLK),
    .rst(RST),
    .clr(err_cnt_clr),
    .inc(err_inc),
    .cnt(err_cnt)
  );
`else
  logic unused_err_cnt_clr;

  assign unused_err_cnt_clr = err_cnt_clr;
  assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_uart_par_chk_seq.sv
// Directed bench for uart_par_chk_seq (DATA_WIDTH=8, CNT_WIDTH=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_uart_par_chk_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PAR_EN;
  logic [1:0] PAR_MODE;
  logic       frame_start;
  logic       data_bit_vld;
  logic       data_bit;
  logic       par_bit_vld;
  logic       par_bit;
  logic       par_done;
  logic       par_err;
  logic       seq_err;
  logic [1:0] err_cnt;
  logic       err_cnt_clr;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef UART_PAR_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  uart_par_chk_seq #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PAR_EN      (PAR_EN),
    .PAR_MODE    (PAR_MODE),
    .frame_start (frame_start),
    .data_bit_vld(data_bit_vld),
    .data_bit    (data_bit),
    .par_bit_vld (par_bit_vld),
    .par_bit     (par_bit),
    .par_done    (par_done),
    .par_err     (par_err),
    .seq_err     (seq_err),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic en, input logic [1:0] mode);
    frame_start = 1'b1;
    PAR_EN      = en;
    PAR_MODE    = mode;
    step();
    frame_start = 1'b0;
  endtask

  task automatic bits(input logic [8:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      data_bit_vld = 1'b1;
      data_bit     = d[i];
      step();
    end
    data_bit_vld = 1'b0;
    data_bit     = 1'b0;
  endtask

  task automatic par(input logic b);
    par_bit_vld = 1'b1;
    par_bit     = b;
    step();
    par_bit_vld = 1'b0;
    par_bit     = 1'b0;
  endtask

  initial begin
    logic [1:0] cnt_exp [5];
    cnt_exp[0] = 2'd1; cnt_exp[1] = 2'd2; cnt_exp[2] = 2'd3;
    cnt_exp[3] = 2'd3; cnt_exp[4] = 2'd3;

    RST = 1'b1; PAR_EN = 1'b0; PAR_MODE = 2'd0; frame_start = 1'b0;
    data_bit_vld = 1'b0; data_bit = 1'b0; par_bit_vld = 1'b0; par_bit = 1'b0;
    err_cnt_clr = 1'b0;
    step(); step();
    check("rst_done", 8'(par_done), 8'd0);
    check("rst_err",  8'(par_err),  8'd0);
    check("rst_seq",  8'(seq_err),  8'd0);
    check("rst_cnt",  8'(err_cnt),  8'd0);
    RST = 1'b0;
    step();

    // Even, 0xA5 (four ones): expected parity 0.
    start(1'b1, 2'd0); bits(9'h0A5, 8); par(1'b0);
    check("even_ok_done", 8'(par_done), 8'd1);
    check("even_ok_err",  8'(par_err),  8'd0);
    check("even_ok_seq",  8'(seq_err),  8'd0);
    step();
    check("even_ok_pulse", 8'(par_done), 8'd0);

    start(1'b1, 2'd0); bits(9'h0A5, 8); par(1'b1);
    check("even_bad_done", 8'(par_done), 8'd1);
    check("even_bad_err",  8'(par_err),  8'd1);
    step(); step();
    check("even_bad_hold", 8'(par_err),  8'd1);
    check("even_bad_pdn",  8'(par_done), 8'd0);

    // Odd, 0x07 (three ones): acc=1, expected 0.
    start(1'b1, 2'd1);
    check("fs_clears_err", 8'(par_err), 8'd0);
    bits(9'h007, 8); par(1'b0);
    check("odd_done", 8'(par_done), 8'd1);
    check("odd_err",  8'(par_err),  8'd0);

    start(1'b1, 2'd2); bits(9'h007, 8); par(1'b0);
    check("mark_done", 8'(par_done), 8'd1);
    check("mark_err",  8'(par_err),  8'd1);

    start(1'b1, 2'd3); bits(9'h007, 8); par(1'b0);
    check("space_done", 8'(par_done), 8'd1);
    check("space_err",  8'(par_err),  8'd0);

    // Early parity after 5 bits.
    start(1'b1, 2'd0); bits(9'h0FF, 5); par(1'b1);
    check("early_seq",  8'(seq_err),  8'd1);
    check("early_done", 8'(par_done), 8'd0);
    check("early_err",  8'(par_err),  8'd0);
    step();
    check("early_seq_pulse", 8'(seq_err), 8'd0);
    bits(9'h0FF, 3); par(1'b1);
    check("idle_ign_seq",  8'(seq_err),  8'd0);
    check("idle_ign_done", 8'(par_done), 8'd0);

    // Ninth data bit before parity.
    start(1'b1, 2'd0); bits(9'h0A5, 8); bits(9'h001, 1);
    check("extra_seq",  8'(seq_err),  8'd1);
    check("extra_done", 8'(par_done), 8'd0);
    par(1'b0);
    check("extra_then_par", 8'(par_done), 8'd0);

    // Both strobes together in WAIT_PAR.
    start(1'b1, 2'd0); bits(9'h0A5, 8);
    data_bit_vld = 1'b1; par_bit_vld = 1'b1; step();
    data_bit_vld = 1'b0; par_bit_vld = 1'b0;
    check("both_seq",  8'(seq_err),  8'd1);
    check("both_done", 8'(par_done), 8'd0);

    // Mode switched even->odd after 3 bits; even must still apply (exp 1).
    start(1'b1, 2'd0); bits(9'h007, 3); PAR_MODE = 2'd1;
    bits(9'h000, 5); par(1'b1);
    PAR_MODE = 2'd0;
    check("mode_latch_done", 8'(par_done), 8'd1);
    check("mode_latch_err",  8'(par_err),  8'd0);

    // Restart after 3 ones, then 0xFF even with parity 0.
    start(1'b1, 2'd0); bits(9'h007, 3);
    start(1'b1, 2'd0); bits(9'h0FF, 8); par(1'b0);
    check("restart_done", 8'(par_done), 8'd1);
    check("restart_err",  8'(par_err),  8'd0);
    check("restart_seq",  8'(seq_err),  8'd0);

    // Data strobe alongside frame_start is dropped.
    frame_start = 1'b1; PAR_EN = 1'b1; PAR_MODE = 2'd0;
    data_bit_vld = 1'b1; data_bit = 1'b1; step();
    frame_start = 1'b0; data_bit_vld = 1'b0; data_bit = 1'b0;
    check("fs_strobe_seq", 8'(seq_err), 8'd0);
    bits(9'h0A5, 8); par(1'b0);
    check("fs_strobe_done", 8'(par_done), 8'd1);
    check("fs_strobe_err",  8'(par_err),  8'd0);

    // PAR_EN=0 clears par_err and leaves the checker idle.
    start(1'b1, 2'd0); bits(9'h0A5, 8); par(1'b1);
    check("dis_pre_err", 8'(par_err), 8'd1);
    start(1'b0, 2'd0);
    check("dis_clr_err", 8'(par_err), 8'd0);
    bits(9'h0FF, 8); par(1'b1);
    check("dis_done", 8'(par_done), 8'd0);
    check("dis_seq",  8'(seq_err),  8'd0);

    // RST while par_done/par_err are high.
    start(1'b1, 2'd0); bits(9'h0A5, 8); par(1'b1);
    RST = 1'b1; step(); RST = 1'b0;
    check("rst_pd_done", 8'(par_done), 8'd0);
    check("rst_pd_err",  8'(par_err),  8'd0);

    // RST after 4 data bits.
    start(1'b1, 2'd1); bits(9'h0A5, 4);
    RST = 1'b1; step(); RST = 1'b0;
    check("rst_mid_done", 8'(par_done), 8'd0);
    check("rst_mid_err",  8'(par_err),  8'd0);
    check("rst_mid_seq",  8'(seq_err),  8'd0);
    bits(9'h0A5, 8); par(1'b0);
    check("rst_mid_idle", 8'(par_done), 8'd0);

    // RST coinciding with the parity strobe.
    start(1'b1, 2'd0); bits(9'h0A5, 8);
    RST = 1'b1; par_bit_vld = 1'b1; par_bit = 1'b1; step();
    RST = 1'b0; par_bit_vld = 1'b0; par_bit = 1'b0;
    check("rst_par_done", 8'(par_done), 8'd0);
    check("rst_par_err",  8'(par_err),  8'd0);

    // Full frame after reset: odd 0x07 expects 0, send 1.
    start(1'b1, 2'd1); bits(9'h007, 8); par(1'b1);
    check("post_rst_done", 8'(par_done), 8'd1);
    check("post_rst_err",  8'(par_err),  8'd1);

    // Error counter: reset, then five bad frames (stays 0 without the feature).
    RST = 1'b1; step(); RST = 1'b0;
    for (int f = 0; f < 5; f++) begin
      start(1'b1, 2'd0); bits(9'h0A5, 8); par(1'b1);
      step();
      check($sformatf("cnt_frame%0d", f), 8'(err_cnt), CntEn ? 8'(cnt_exp[f]) : 8'd0);
    end

    // Clear coinciding with a bad-frame par_done wins over the increment.
    start(1'b1, 2'd0); bits(9'h0A5, 8); par(1'b1);
    err_cnt_clr = 1'b1; step(); err_cnt_clr = 1'b0;
    check("cnt_clr_wins", 8'(err_cnt), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
